// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring unsigned divider. One shift/subtract step per clock,
//   MSB first, behind a start/busy/done handshake. Produces
//   quotient_o = dividend_i / divisor_i and remainder_o = dividend_i % divisor_i.
//
//   Optional feature macro: DIVZERO_DETECT_EN
//     defined   : a zero divisor skips the iteration, done fires one cycle after
//                 the start edge, quotient = all ones, remainder = dividend,
//                 div_by_zero_o = 1.
//     undefined : no detection logic; a zero divisor runs the normal WIDTH-step
//                 path (which naturally yields all ones / dividend) and
//                 div_by_zero_o is tied low.
//
// Ports
//   clk            in   1      clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   start_i        in   1      request, sampled only in IDLE or DONE
//   dividend_i     in   WIDTH  numerator, captured on accepted start
//   divisor_i      in   WIDTH  denominator, captured on accepted start
//   busy_o         out  1      high while iterating
//   done_o         out  1      one-cycle pulse, results valid
//   quotient_o     out  WIDTH  result, held until next accepted start
//   remainder_o    out  WIDTH  result, held until next accepted start
//   div_by_zero_o  out  1      high with done for a zero divisor (macro build)
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // n_q holds the not-yet-consumed dividend bits; quotient bits shift in at
  // the LSB as dividend bits leave at the MSB.
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  // The partial remainder is always < divisor after a step, so WIDTH bits are
  // enough to store it; the extra bit only exists in the shifted value.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   r_shift;
  logic             ge;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] n_step;

  // One restoring step. When ge is set the true difference is below the
  // divisor, so computing it modulo 2^WIDTH loses nothing.
  always_comb begin
    r_shift = {r_q, n_q[WIDTH-1]};
    ge      = (r_shift >= {1'b0, d_q});
    r_step  = ge ? (r_shift[WIDTH-1:0] - d_q) : r_shift[WIDTH-1:0];
    n_step  = {n_q[WIDTH-2:0], ge};
  end

`ifdef DIVZERO_DETECT_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    d_d     = d_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIVZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          cnt_d   = '0;
          n_d     = dividend_i;
          d_d     = divisor_i;
          r_d     = '0;
          quot_d  = '0;
          rem_d   = '0;
`ifdef DIVZERO_DETECT_EN
          dbz_d   = 1'b0;
          if (divisor_i == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend_i;
            dbz_d   = 1'b1;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d   = r_step;
        n_d   = n_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          quot_d  = n_step;
          rem_d   = r_step;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIVZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      d_q     <= d_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIVZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  // Status outputs are decodes of the state register only.
  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
`ifdef DIVZERO_DETECT_EN
  assign div_by_zero_o = dbz_q;
`else
  assign div_by_zero_o = 1'b0;
`endif

endmodule
